// File: rtl/block_mem_responder.sv
// block_mem_responder: single-outstanding block memory slave with programmable latency and tristated read bus
module block_mem_responder #(
  parameter int    ADDR_W    = 10,
  parameter int    DATA_W    = 20,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data_bus,
  output logic              mem_ready
);
  localparam int DEPTH = 2 ** (ADDR_W - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-2:0] idx_q, idx_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic              ready_q, ready_d;
  logic              wr_en, drive_en;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              unused_offset;
  assign unused_offset = mem_addr[0];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wbuf_d  = wbuf_q;
    case (state_q)
      IDLE: if (mem_req) begin
        rw_d    = mem_rw;
        idx_d   = mem_addr[ADDR_W-1:1];
        wbuf_d  = mem_rw ? mem_data_bus : '0;
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESPOND : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = !mem_req ? IDLE : (cnt_q == 4'd1) ? RESPOND : WAIT;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == RESPOND;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wbuf_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wbuf_q  <= wbuf_d;
      ready_q <= ready_d;
    end
  end
  assign wr_en = !rst && state_q == RESPOND && rw_q;
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx_q] <= wbuf_q;
  end
  assign drive_en     = state_q == RESPOND && !rw_q && !mem_rw;
  assign mem_data_bus = drive_en ? mem_q[idx_q] : 'z;
  assign mem_ready    = ready_q;
endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: scoreboard bench over three responders with latencies 2, 1 and 5.
module tb_block_mem_responder;
    localparam int LAT [3] = '{2, 1, 5};

    typedef struct {
        bit          rw;
        logic [19:0] d;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req [3];
    logic        rw [3];
    logic [9:0]  addr [3];
    logic [19:0] drv [3];
    logic        oe [3];
    logic        rdy [3];
    logic [19:0] bus_rd [3];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_rdy [3];
    int          r1;
    exp_t        exp_q [3][$];
    logic [19:0] model [3][512];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic monitor(input int i);
        exp_t e;
        if (rdy[i]) begin
            last_rdy[i] = cyc;
            if (exp_q[i].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready inst %0d: got ready=1 want 0 (cycle %0d)", i, cyc);
            end else begin
                e = exp_q[i].pop_front();
                check($sformatf("ready_latency_i%0d", i), cyc, e.acc + LAT[i] - 1);
                check(e.rw ? $sformatf("write_bus_z_i%0d", i) : $sformatf("read_data_i%0d", i),
                      {12'd0, bus_rd[i]}, {12'd0, e.rw ? 20'hFFFFF : e.d});
            end
        end else if (!oe[i]) begin
            check($sformatf("idle_bus_z_i%0d", i), {12'd0, bus_rd[i]}, 32'hFFFFF);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wire [19:0] bus;
        for (genvar b = 0; b < 20; b++) begin : g_pu
            pullup (bus[b]);
        end
        assign bus       = oe[g] ? drv[g] : 'z;
        assign bus_rd[g] = bus;
        block_mem_responder #(.LATENCY(LAT[g])) dut (
            .clk(clk),
            .rst(rst),
            .mem_req(req[g]),
            .mem_rw(rw[g]),
            .mem_addr(addr[g]),
            .mem_data_bus(bus),
            .mem_ready(rdy[g])
        );
        always @(negedge clk) monitor(g);
    end

    // Called #1 after a posedge while the responder is idle; returns #1 after the
    // posedge that closes the response cycle, leaving req high when hold is set.
    task automatic txn(input int i, input bit w, input int a, input logic [19:0] d, input bit hold);
        exp_t e;
        int   idx;
        bit   got;
        idx     = a[9:1];
        req[i]  = 1'b1;
        rw[i]   = w;
        addr[i] = a[9:0];
        drv[i]  = d;
        oe[i]   = w;
        e.rw    = w;
        e.d     = w ? d : model[i][idx];
        e.acc   = cyc + 1;
        if (w) model[i][idx] = d;
        exp_q[i].push_back(e);
        @(posedge clk);
        #1;
        oe[i]   = 1'b0;
        addr[i] = 10'($urandom);
        drv[i]  = 20'($urandom);
        got = 1'b0;
        for (int k = 0; k < LAT[i] + 4 && !got; k++) begin
            @(negedge clk);
            got = rdy[i];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout inst %0d: got no ready want ready within %0d cycles", i, LAT[i] + 4);
        end
        @(posedge clk);
        #1;
        if (!hold) req[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0;
            rw[i] = 1'b0;
            addr[i] = '0;
            drv[i] = '0;
            oe[i] = 1'b0;
            last_rdy[i] = 0;
            for (int j = 0; j < 512; j++) model[i][j] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("reset_ready_i%0d", i), rdy[i], 0);
        @(posedge clk);
        #1;

        txn(0, 0, 50, 20'h0, 0);
        txn(0, 1, 84, 20'h4B12C, 0);
        txn(0, 0, 85, 20'h0, 0);

        txn(0, 1, 70, 20'h30A0F, 1);
        r1 = last_rdy[0];
        txn(0, 0, 222, 20'h0, 0);
        check("b2b_spacing", last_rdy[0] - r1, LAT[0] + 1);
        txn(0, 0, 70, 20'h0, 0);

        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 10'd148; drv[0] = 20'hFFFFF; oe[0] = 1'b1;
        @(posedge clk);
        #1 req[0] = 1'b0; oe[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_ready", rdy[0], 0);
        end
        @(posedge clk);
        #1;
        txn(0, 0, 148, 20'h0, 0);

        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 10'd300; drv[0] = 20'h12345; oe[0] = 1'b1;
        @(posedge clk);
        #1 oe[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_ready", rdy[0], 0);
        @(posedge clk);
        #1 rst = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        check("post_rst_ready", rdy[0], 0);
        @(posedge clk);
        #1;
        txn(0, 0, 300, 20'h0, 0);
        txn(0, 1, 300, 20'h0ABCD, 0);
        txn(0, 0, 301, 20'h0, 0);

        txn(1, 1, 12, 20'h5A5A5, 1);
        txn(1, 0, 13, 20'h0, 0);
        txn(2, 1, 12, 20'h13579, 1);
        txn(2, 0, 12, 20'h0, 0);

        for (int i = 0; i < 3; i++) begin
            repeat (40) txn(i, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                            20'($urandom), 1'($urandom_range(0, 1)));
            req[i] = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end

        repeat (10) @(posedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("pending_i%0d", i), exp_q[i].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
